// File: rtl/fsm_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package fsm_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Out-of-range load values snap to the top legal state.
  function automatic int unsigned clamp(input int unsigned v, input int unsigned m);
    return (v >= m) ? m - 1 : v;
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-state function for the modulo-N counter: load > count > hold.
module mod_n_next
  import fsm_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] state,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term,
  output logic             ovf_set
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  always_comb begin
    at_term = (up == DIR_UP) ? (state == MAXV) : (state == '0);
    nxt     = state;
    ovf_set = 1'b0;
    if (load) begin
      nxt = WIDTH'(clamp(32'(load_val), 32'(MODULUS)));
    end else if (en) begin
      if (!at_term)
        nxt = (up == DIR_UP) ? state + WIDTH'(1) : state - WIDTH'(1);
      else if (sat == MODE_SAT)
        ovf_set = 1'b1;
      else
        // wrap stays inside 0..MODULUS-1, not 0..2^WIDTH-1
        nxt = (up == DIR_UP) ? '0 : MAXV;
    end
  end

endmodule

// File: rtl/mod_n_counter_fsm.sv
// Modulo-N up/down counter with load, wrap/saturate mode, sticky overflow and cascade carry.
module mod_n_counter_fsm
  import fsm_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] nxt;
  logic             at_term;
  logic             ovf_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      if (load)         ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
    end
  end

  mod_n_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .state    (state),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .nxt      (nxt),
    .at_term  (at_term),
    .ovf_set  (ovf_set)
  );

  // Reset also gates cout: state=0 with up=0 would otherwise look terminal.
  always_comb begin
    cout = reset & en & ~load & at_term;
  end

endmodule

// File: tb/tb_mod_n_counter_fsm.sv
// Directed plus random checks of mod_n_counter_fsm against an arithmetic reference model.
module tb_mod_n_counter_fsm;

  localparam int M = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1, up = 1'b0, sat = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] state;
  logic       cout, ovf;

  logic       cen = 1'b0;
  logic [2:0] c0_state;
  logic [1:0] c1_state;
  logic       c0_cout, c1_cout, c0_ovf, c1_ovf;

  int checks = 0;
  int errors = 0;
  int m_s = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  mod_n_counter_fsm #(.WIDTH(3), .MODULUS(M)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .state(state), .cout(cout), .ovf(ovf)
  );

  mod_n_counter_fsm #(.WIDTH(3), .MODULUS(6)) c0 (
    .clk(clk), .reset(reset), .en(cen), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(3'd0), .state(c0_state), .cout(c0_cout), .ovf(c0_ovf)
  );

  mod_n_counter_fsm #(.WIDTH(2), .MODULUS(4)) c1 (
    .clk(clk), .reset(reset), .en(c0_cout), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(2'd0), .state(c1_state), .cout(c1_cout), .ovf(c1_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check cout before the edge, state/ovf after it.
  task automatic cyc(input logic e, input logic u, input logic s, input logic l,
                     input logic [2:0] lv);
    bit term;
    en = e; up = u; sat = s; load = l; load_val = lv;
    #1;
    term = u ? (m_s == M - 1) : (m_s == 0);
    chk("cout", {31'd0, cout}, {31'd0, e && !l && term});
    @(posedge clk);
    if (l) begin
      m_s   = (int'(lv) >= M) ? M - 1 : int'(lv);
      m_ovf = 0;
    end else if (e) begin
      if (term && s) m_ovf = 1;
      else           m_s = u ? (m_s + 1) % M : (m_s + M - 1) % M;
    end
    #1;
    chk("state", {29'd0, state}, m_s);
    chk("ovf", {31'd0, ovf}, m_ovf);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with en=1, up=0: state 0 would be terminal, cout must still be 0
    #3;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // up count with wrap: 1..5,0,1
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 0);
    // back to 0, then down-count borrow 0 -> 5 -> 4
    cyc(0, 1, 0, 1, 3'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // saturate from 4: 5, 5, 5 with sticky ovf; load clears it
    cyc(0, 1, 1, 1, 3'd4);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 3'd2);
    // load priority and clamp; en=1 at a terminal-adjacent state
    cyc(1, 1, 0, 1, 3'd7);
    cyc(1, 1, 1, 0, 0);
    // ovf survives plain counting, then async reset mid-count clears all
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pre_rst_state", {29'd0, state}, 3);
    en = 1'b1; up = 1'b0; load = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_state", {29'd0, state}, 0);
    chk("async_ovf", {31'd0, ovf}, 0);
    chk("async_cout", {31'd0, cout}, 0);
    #2;
    reset = 1'b1;
    m_s = 0; m_ovf = 0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));

    // cascade: second stage advances once per 6, combined wraps at 24
    en = 1'b0; load = 1'b0;
    chk("casc_init0", {29'd0, c0_state}, 0);
    chk("casc_init1", {30'd0, c1_state}, 0);
    cen = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      chk("casc_lo", {29'd0, c0_state}, k % 6);
      chk("casc_hi", {30'd0, c1_state}, (k / 6) % 4);
    end
    cen = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
